vga_pixel_unpack: RTL
=====================

# vga_pixel_unpack

Parametrised pixel unpacker between the DDR read FIFO and the VGA DAC pins. It pulls WORD_W-bit show-ahead FIFO words and splits each into 32-bit RGB888 or 16-bit RGB565 pixel slots. Each slot is emitted on a `pixel_valid` strobe from the external timing generator. It holds the timing generator in reset until data or a test pattern is available, muxes in a test pattern, and detects FIFO underrun. After an underrun it recovers cleanly at the next frame boundary.

## Interface
- `WORD_W`, 128, FIFO word width; multiple of 32, minimum 32.
- `CNT_W`, 16, underrun counter width.
- `UNDERRUN_RGB`, 24'hFF00FF, colour driven while underrun; `{b,g,r}`.

- `vga_clk`  in  1  pixel clock.
- `vga_reset_n`  in  1  reset; asynchronous, active-low. Clock is `vga_clk`.
- `test_pat`  in  1  level; selects the `test_*` colour inputs and suppresses FIFO consumption.
- `pix_mode`  in  1  0 = RGB888 in 32-bit slots; 1 = RGB565 in 16-bit slots; quasi-static.
- `test_r`/`test_g`/`test_b`  in  8 each  test pattern colour from the timing generator.
- `pixel_valid`  in  1  active-pixel strobe from the timing generator.
- `frame_start`  in  1  single-cycle pulse in vertical blanking before each frame.
- `fifo_empty`  in  1  FIFO empty.
- `fifo_rd_data`  in  WORD_W  show-ahead FIFO head word.
- `fifo_rd`  out  1  combinational pop; asserted for one cycle per consumed or discarded word.
- `sync_reset`  out  1  active-high reset to the timing generator.
- `vga_r`/`vga_g`/`vga_b`  out  8 each  registered pixel colour.
- `vga_de`  out  1  registered `pixel_valid`, aligned with the colour outputs.
- `underrun`  out  1  high while in UNDERRUN.
- `underrun_cnt`  out  CNT_W  saturating count of underrun events.
- `align_err`  out  1  sticky; set on a misaligned frame start.

## Operation
- States: IDLE, RUN, UNDERRUN.
  - IDLE: `sync_reset`=1. Leaves to RUN when `~fifo_empty | test_pat`; `sync_reset` drops to 0 on the following cycle.
  - RUN: normal unpacking.
  - UNDERRUN: entered when `pixel_valid & ~test_pat & fifo_empty` in RUN. Returns to RUN on `frame_start`.
  - IDLE is re-entered only via reset.
- `mode_q` captures `pix_mode` while in IDLE and on every `frame_start`.
- SLOTS = WORD_W/32 for mode 0, WORD_W/16 for mode 1. Slot counter `slot` runs 0..SLOTS-1.
- Consume condition: RUN & `pixel_valid` & `~test_pat` & `~fifo_empty`.
  - Output the slot colour.
  - `slot` increments.
  - At `slot` = SLOTS-1, `fifo_rd`=1 and `slot` wraps to 0.
- Slot extraction:
  - Mode 0: s = `fifo_rd_data[slot*32 +: 32]`. r=s[7:0], g=s[15:8], b=s[23:16]; s[31:24] ignored.
  - Mode 1: s = `fifo_rd_data[slot*16 +: 16]`. r={s[15:11],s[15:13]}, g={s[10:5],s[10:9]}, b={s[4:0],s[4:2]} (MSB replication).
- Colour selection:
  - `test_pat`=1 (any state except IDLE): `test_*` inputs are output, `slot` is held, and there is no pop.
  - UNDERRUN with `test_pat`=0: `UNDERRUN_RGB` is output for every `pixel_valid`, with no pops.
  - Underrun cycle itself (entry into UNDERRUN): outputs `UNDERRUN_RGB`, no pop, slot held.
- `frame_start` in RUN or UNDERRUN:
  - If `slot`≠0 and `~fifo_empty`: pop the partial word (`fifo_rd`=1) and set `align_err`.
  - `slot` is forced to 0.
- `frame_start` and `pixel_valid` in the same cycle: `frame_start` processing only; the pixel is output as black and `align_err` is set.
- Underrun count: `underrun_cnt` increments once per RUN→UNDERRUN transition and saturates at all-ones.

## Timing
- Reset values:
  - state = IDLE, `sync_reset`=1, `slot`=0, `mode_q`=0.
  - `vga_r`/`vga_g`/`vga_b`=0, `vga_de`=0.
  - `underrun`=0, `underrun_cnt`=0, `align_err`=0.
  - `fifo_rd`=0.
- Latency:
  - `pixel_valid` at cycle N → colour and `vga_de` valid at N+1.
  - When `pixel_valid`=0, the colour registers load 0 (blanking).
- Pop timing:
  - `fifo_rd` is asserted in the same cycle as the last slot's `pixel_valid`.
  - The next word must be at the FIFO head by the next `pixel_valid`.
  - `fifo_rd` is never asserted when `fifo_empty`=1.
- Reset assertion mid-frame returns all state to reset values asynchronously; no further pops occur.

## Configuration
- `VGA_UNPACK_STATS_EN` defined: `underrun_cnt` and `align_err` are implemented as above.
- Not defined:
  - `underrun_cnt` tied to 0 and `align_err` tied to 0.
  - Their registers are removed.
  - State machine, UNDERRUN colour, `underrun` output and realignment pops are unchanged.

## Test plan
- Reset, then `fifo_empty`=0 with WORD_W=128, mode 0 and head word 0x44332211_..._04030201. Expected: `sync_reset` falls 2 cycles later. Four `pixel_valid` strobes → pixels r,g,b = 01,02,03 first and 11,22,33 fourth. `fifo_rd` pulses on the 4th strobe only.
- Mode 1, slot value 16'hF81F. Expected: r=FF, g=00, b=FF. Eight strobes per word, one pop.
- `fifo_empty` rises mid-frame. Expected: UNDERRUN colour FF/00/FF on every remaining strobe, no pops, `underrun_cnt`=1. After `frame_start`: back to RUN, slot 0.
- `frame_start` with `slot`=2 in mode 0. Expected: single `fifo_rd` pulse and `align_err`=1 (macro defined); `align_err` stays 0 with the macro undefined.
- `test_pat`=1 for 10 strobes mid-word. Expected: test colours out, no pops. After `test_pat` drops, unpacking resumes at the held slot.
- Assert `vga_reset_n` low mid-line. Expected: all outputs at reset values immediately, `sync_reset`=1.

Source files
------------

// File: rtl/vga_pixel_unpack.sv
// ============================================================================
// vga_pixel_unpack
// ----------------------------------------------------------------------------
// Unpacks WORD_W-bit words from a show-ahead DDR read FIFO into RGB pixels for
// the VGA DAC. Each word carries WORD_W/32 RGB888 slots (pix_mode=0) or
// WORD_W/16 RGB565 slots (pix_mode=1); one slot is emitted per pixel_valid
// strobe from the external timing generator. The timing generator is held in
// reset until data or a test pattern is available. A FIFO underrun paints
// UNDERRUN_RGB until the next frame_start, which also realigns the word
// boundary by discarding any partially consumed word.
//
// Optional feature macro: VGA_UNPACK_STATS_EN
//   defined   : underrun_cnt_o (saturating) and sticky align_err_o implemented
//   undefined : both outputs tied to 0 and their registers removed
//
// Parameters
//   WORD_W        FIFO word width (multiple of 32, >= 32)
//   CNT_W         underrun counter width
//   UNDERRUN_RGB  colour shown during underrun, packed {b,g,r}
//
// Ports
//   vga_clk, vga_reset_n   pixel clock, asynchronous active-low reset
//   test_pat_i             select test_*_i colours, suppress FIFO consumption
//   pix_mode_i             0 = RGB888/32-bit slots, 1 = RGB565/16-bit slots
//   test_r/g/b_i           test pattern colour
//   pixel_valid_i          active-pixel strobe
//   frame_start_i          one-cycle pulse in vertical blanking
//   fifo_empty_i           FIFO empty
//   fifo_rd_data_i         FIFO head word (show-ahead)
//   fifo_rd_o              combinational pop, one cycle per consumed/dropped word
//   sync_reset_o           active-high reset to the timing generator
//   vga_r/g/b_o, vga_de_o  registered pixel colour and data enable
//   underrun_o             high while in UNDERRUN
//   underrun_cnt_o         saturating count of underrun events
//   align_err_o            sticky misaligned-frame-start flag
// ============================================================================
module vga_pixel_unpack #(
    parameter int unsigned WORD_W       = 128,
    parameter int unsigned CNT_W        = 16,
    parameter logic [23:0] UNDERRUN_RGB = 24'hFF00FF
) (
    input  logic              vga_clk,
    input  logic              vga_reset_n,
    input  logic              test_pat_i,
    input  logic              pix_mode_i,
    input  logic [7:0]        test_r_i,
    input  logic [7:0]        test_g_i,
    input  logic [7:0]        test_b_i,
    input  logic              pixel_valid_i,
    input  logic              frame_start_i,
    input  logic              fifo_empty_i,
    input  logic [WORD_W-1:0] fifo_rd_data_i,
    output logic              fifo_rd_o,
    output logic              sync_reset_o,
    output logic [7:0]        vga_r_o,
    output logic [7:0]        vga_g_o,
    output logic [7:0]        vga_b_o,
    output logic              vga_de_o,
    output logic              underrun_o,
    output logic [CNT_W-1:0]  underrun_cnt_o,
    output logic              align_err_o
);

    localparam int unsigned SLOTS32 = WORD_W / 32;
    localparam int unsigned SLOTS16 = WORD_W / 16;
    localparam int unsigned SLOT_W  = $clog2(SLOTS16);

    localparam logic [SLOT_W-1:0] LAST32 = SLOT_W'(SLOTS32 - 1);
    localparam logic [SLOT_W-1:0] LAST16 = SLOT_W'(SLOTS16 - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_UNDERRUN = 2'd2
    } state_t;

    // Field order matches the {b,g,r} packing of UNDERRUN_RGB and RGB888 slots.
    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } rgb_t;

    localparam rgb_t UR_RGB = rgb_t'(UNDERRUN_RGB);
    localparam rgb_t BLACK  = rgb_t'(24'h000000);

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic               mode_q, mode_d;
    rgb_t               colour_q, colour_d;
    logic               de_q;
    logic               sync_reset_q;
    logic               underrun_q;

    logic               fifo_rd_c;
    logic               align_set_c;
    logic               cnt_inc_c;
    logic               slot_last_c;
    logic [23:0]        word32_c;
    logic [15:0]        word16_c;
    rgb_t               slot_rgb_c;

    // ------------------------------------------------------------------
    // Slot extraction from the FIFO head word
    // ------------------------------------------------------------------
    always_comb begin
        word32_c = '0;
        word16_c = '0;
        // Byte 3 of an RGB888 slot is padding and never selected.
        for (int i = 0; i < int'(SLOTS32); i++) begin
            if (slot_q == SLOT_W'(i)) begin
                word32_c = fifo_rd_data_i[i*32 +: 24];
            end
        end
        for (int i = 0; i < int'(SLOTS16); i++) begin
            if (slot_q == SLOT_W'(i)) begin
                word16_c = fifo_rd_data_i[i*16 +: 16];
            end
        end

        slot_rgb_c = rgb_t'(word32_c);
        if (mode_q) begin
            // RGB565 widened by replicating the channel MSBs into the LSBs.
            slot_rgb_c.r = {word16_c[15:11], word16_c[15:13]};
            slot_rgb_c.g = {word16_c[10:5],  word16_c[10:9]};
            slot_rgb_c.b = {word16_c[4:0],   word16_c[4:2]};
        end
    end

    assign slot_last_c = mode_q ? (slot_q == LAST16) : (slot_q == LAST32);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_i || test_pat_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // A frame_start cycle never counts as a pixel, so it cannot underrun.
                if (!frame_start_i && pixel_valid_i && !test_pat_i && fifo_empty_i) begin
                    state_d = ST_UNDERRUN;
                end
            end
            ST_UNDERRUN: begin
                if (frame_start_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs - pop, slot advance, pixel colour, stats events
    // ------------------------------------------------------------------
    always_comb begin
        fifo_rd_c   = 1'b0;
        align_set_c = 1'b0;
        slot_d      = slot_q;
        colour_d    = BLACK;
        mode_d      = mode_q;

        if (state_q == ST_IDLE || frame_start_i) begin
            mode_d = pix_mode_i;
        end

        if (state_q != ST_IDLE) begin
            if (frame_start_i) begin
                // Realign to a word boundary; a coincident pixel is blanked.
                slot_d = '0;
                if (slot_q != '0 && !fifo_empty_i) begin
                    fifo_rd_c   = 1'b1;
                    align_set_c = 1'b1;
                end
                if (pixel_valid_i) begin
                    align_set_c = 1'b1;
                end
            end else if (pixel_valid_i) begin
                if (test_pat_i) begin
                    colour_d = '{b: test_b_i, g: test_g_i, r: test_r_i};
                end else if (state_q == ST_UNDERRUN || fifo_empty_i) begin
                    // Covers both the underrun entry cycle and the UNDERRUN state.
                    colour_d = UR_RGB;
                end else begin
                    colour_d = slot_rgb_c;
                    if (slot_last_c) begin
                        fifo_rd_c = 1'b1;
                        slot_d    = '0;
                    end else begin
                        slot_d = slot_q + SLOT_W'(1);
                    end
                end
            end
        end
    end

    assign cnt_inc_c = (state_q == ST_RUN) && (state_d == ST_UNDERRUN);

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            slot_q       <= '0;
            mode_q       <= 1'b0;
            colour_q     <= BLACK;
            de_q         <= 1'b0;
            sync_reset_q <= 1'b1;
            underrun_q   <= 1'b0;
        end else begin
            slot_q       <= slot_d;
            mode_q       <= mode_d;
            colour_q     <= colour_d;
            de_q         <= pixel_valid_i;
            sync_reset_q <= (state_q == ST_IDLE);
            underrun_q   <= (state_d == ST_UNDERRUN);
        end
    end

    assign fifo_rd_o    = fifo_rd_c;
    assign sync_reset_o = sync_reset_q;
    assign vga_r_o      = colour_q.r;
    assign vga_g_o      = colour_q.g;
    assign vga_b_o      = colour_q.b;
    assign vga_de_o     = de_q;
    assign underrun_o   = underrun_q;

    // ------------------------------------------------------------------
    // Optional statistics
    // ------------------------------------------------------------------
`ifdef VGA_UNPACK_STATS_EN
    logic [CNT_W-1:0] underrun_cnt_q;
    logic             align_err_q;

    always_ff @(posedge vga_clk or negedge vga_reset_n) begin
        if (!vga_reset_n) begin
            underrun_cnt_q <= '0;
            align_err_q    <= 1'b0;
        end else begin
            if (cnt_inc_c && (underrun_cnt_q != '1)) begin
                underrun_cnt_q <= underrun_cnt_q + CNT_W'(1);
            end
            if (align_set_c) begin
                align_err_q <= 1'b1;
            end
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
    assign align_err_o    = align_err_q;
`else
    logic unused_stats;
    assign unused_stats   = cnt_inc_c | align_set_c;
    assign underrun_cnt_o = '0;
    assign align_err_o    = 1'b0;
`endif

endmodule
